// File: rtl/queue_pkt_drain_if.sv
// Bundle of the IPQ pop port, the packet result port and the drop counter
// that connects queue_pkt_drain to its environment.
//
// Result handshake: a result transfers at a posedge where ResultValid and
// ResultReady are both 1; once ResultValid rises, ResultLen/ResultSum/ResultErr
// stay stable until that transfer, and ResultReady while ResultValid is 0 has
// no effect.
interface queue_pkt_drain_if;
  logic [31:0] TIE_IPQ;
  logic        TIE_IPQ_Empty;
  logic        TIE_IPQ_PopReq;
  logic        ResultValid;
  logic        ResultReady;
  logic [15:0] ResultLen;
  logic [31:0] ResultSum;
  logic        ResultErr;
  logic [7:0]  DropCnt;
  logic [1:0]  dbg_state;

  // The drain block: pops the queue and drives the result port.
  modport master (
    input  TIE_IPQ, TIE_IPQ_Empty, ResultReady,
    output TIE_IPQ_PopReq, ResultValid, ResultLen, ResultSum, ResultErr,
           DropCnt, dbg_state
  );

  // The environment: supplies queue words and accepts results.
  modport slave (
    output TIE_IPQ, TIE_IPQ_Empty, ResultReady,
    input  TIE_IPQ_PopReq, ResultValid, ResultLen, ResultSum, ResultErr,
           DropCnt, dbg_state
  );
endinterface

// File: rtl/queue_pkt_drain.sv
// queue_pkt_drain: pops 32-bit words from the IPQ side of the TIE queue, frames
// them as header / payload / trailer packets, sums the payload and reports one
// result per packet. Every popped word is consumed in the cycle it is popped.
//
// Header: [31:16] must equal MAGIC, [15:0] is the payload length (<= MAX_LEN).
// Anything else in header position is discarded and counted in DropCnt.
module queue_pkt_drain #(
  parameter logic [15:0] MAGIC   = 16'hA5A5,
  parameter int          MAX_LEN = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  queue_pkt_drain_if.master bus
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_TRL = 2'd2,
    S_RES = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] res_len_q, res_len_d;
  logic [31:0] res_sum_q, res_sum_d;
  logic        res_err_q, res_err_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  drop_q, drop_d;

  logic        pop;
  logic [31:0] word;
  logic        hdr_good;

  assign word     = bus.TIE_IPQ;
  assign hdr_good = (word[31:16] == MAGIC) && (word[15:0] <= MAX_LEN_W);

  // Pop whenever a word is present and the FSM is not parked on a result;
  // Reset blocks the pop combinationally so nothing is lost in a reset cycle.
  assign pop = !Reset && !bus.TIE_IPQ_Empty && (state_q != S_RES);

  // Next-state and datapath: one word of framing work per popped word.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    res_len_d   = res_len_q;
    res_sum_d   = res_sum_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    drop_d      = drop_q;
    case (state_q)
      S_HDR: begin
        if (pop) begin
          if (hdr_good) begin
            len_d   = word[15:0];
            cnt_d   = 16'd0;
            sum_d   = 32'd0;
            state_d = (word[15:0] != 16'd0) ? S_PAY : S_TRL;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      S_PAY: begin
        if (pop) begin
          sum_d = sum_q + word;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) state_d = S_TRL;
        end
      end
      S_TRL: begin
        if (pop) begin
          res_len_d   = len_q;
          res_sum_d   = sum_q;
          res_err_d   = (word != sum_q);
          res_valid_d = 1'b1;
          state_d     = S_RES;
        end
      end
      S_RES: begin
        // ResultValid is always 1 here, so Ready alone completes the transfer.
        if (bus.ResultReady) begin
          res_valid_d = 1'b0;
          state_d     = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // State register with synchronous reset; a partial packet is simply abandoned.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_HDR;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      sum_q       <= 32'd0;
      res_len_q   <= 16'd0;
      res_sum_q   <= 32'd0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      res_len_q   <= res_len_d;
      res_sum_q   <= res_sum_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.TIE_IPQ_PopReq = pop;
  assign bus.ResultValid    = res_valid_q;
  assign bus.ResultLen      = res_len_q;
  assign bus.ResultSum      = res_sum_q;
  assign bus.ResultErr      = res_err_q;
  assign bus.DropCnt        = drop_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_queue_pkt_drain.sv
// Directed bench for queue_pkt_drain. A queue of words models the TIE queue
// head; results expected by hand are held in exp_q as {err, len, sum}.
module tb_queue_pkt_drain;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  queue_pkt_drain_if bus ();

  queue_pkt_drain #(.MAGIC(16'hA5A5), .MAX_LEN(64)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus.master)
  );

  // ---------------- queue model / scoreboard ----------------
  logic [31:0] q[$];
  logic [48:0] exp_q[$];
  logic        popped;
  int          tests = 0;
  int          fails = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_q();
    bus.TIE_IPQ       = (q.size() != 0) ? q[0] : 32'd0;
    bus.TIE_IPQ_Empty = (q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    drive_q();
  endtask

  // One clock: present the head word, note whether the DUT pops it at the
  // coming posedge, then retire it from the model just after that edge.
  task automatic tick();
    drive_q();
    #1;
    popped = bus.TIE_IPQ_PopReq && !bus.TIE_IPQ_Empty;
    @(posedge CLK);
    #1;
    if (popped) void'(q.pop_front());
    drive_q();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200 && !bus.ResultValid; i++) tick();
    chk({tag, "_valid"}, 32'(bus.ResultValid), 32'd1);
  endtask

  // Compare the presented result with the oldest expected one, then accept it.
  task automatic take_result(input string tag);
    logic [48:0] e;
    wait_valid(tag);
    e = exp_q.pop_front();
    chk({tag, "_len"}, 32'(bus.ResultLen), 32'(e[47:32]));
    chk({tag, "_sum"}, bus.ResultSum, e[31:0]);
    chk({tag, "_err"}, 32'(bus.ResultErr), 32'(e[48]));
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
    chk({tag, "_ack"}, 32'(bus.ResultValid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pop_n;
    logic [31:0] s;
    Reset           = 1'b1;
    bus.ResultReady = 1'b0;
    drive_q();
    tick();
    tick();
    chk("rst_valid", 32'(bus.ResultValid), 32'd0);
    chk("rst_len",   32'(bus.ResultLen),   32'd0);
    chk("rst_sum",   bus.ResultSum,        32'd0);
    chk("rst_err",   32'(bus.ResultErr),   32'd0);
    chk("rst_drop",  32'(bus.DropCnt),     32'd0);
    Reset = 1'b0;

    // Ready with no result pending is ignored.
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
    chk("idle_ready", 32'(bus.ResultValid), 32'd0);

    // T1: five words popped on five consecutive cycles, result held until Ready.
    push(32'hA5A5_0003); push(32'd1); push(32'd2); push(32'd3); push(32'd6);
    pop_n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (popped) pop_n++;
    end
    chk("t1_pops", 32'(pop_n), 32'd5);
    chk("t1_valid", 32'(bus.ResultValid), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("t1_hold_valid", 32'(bus.ResultValid), 32'd1);
    chk("t1_hold_sum", bus.ResultSum, 32'd6);
    exp_q.push_back({1'b0, 16'd3, 32'd6});
    take_result("t1");

    // T2: wrapping sum, then a bad trailer; words arrive with gaps.
    push(32'hA5A5_0002); tick(); tick();
    push(32'hFFFF_FFFF); tick(); tick(); tick();
    push(32'd2); push(32'd1);
    exp_q.push_back({1'b0, 16'd2, 32'd1});
    take_result("t2_ok");
    push(32'hA5A5_0002); push(32'hFFFF_FFFF); push(32'd2); push(32'd0);
    exp_q.push_back({1'b1, 16'd2, 32'd1});
    take_result("t2_bad");

    // T3: non-MAGIC header and over-long header dropped, then an empty packet.
    push(32'h1234_0001); push(32'hA5A5_0041); push(32'hA5A5_0000); push(32'd0);
    exp_q.push_back({1'b0, 16'd0, 32'd0});
    take_result("t3");
    chk("t3_drop", 32'(bus.DropCnt), 32'd2);

    // T4: backpressure with the next packet queued.
    push(32'hA5A5_0001); push(32'd7); push(32'd7);
    push(32'hA5A5_0001); push(32'd9); push(32'd9);
    wait_valid("t4_first");
    pop_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (popped) pop_n++;
    end
    chk("t4_no_pop", 32'(pop_n), 32'd0);
    chk("t4_q_level", 32'(q.size()), 32'd3);
    chk("t4_stable_sum", bus.ResultSum, 32'd7);
    chk("t4_stable_len", 32'(bus.ResultLen), 32'd1);
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
    chk("t4_ack", 32'(bus.ResultValid), 32'd0);
    tick();
    chk("t4_hdr_next", 32'(popped), 32'd1);
    exp_q.push_back({1'b0, 16'd1, 32'd9});
    take_result("t4_second");

    // T5: reset mid-packet; the next word is treated as a header.
    push(32'hA5A5_0003); push(32'd5);
    tick(); tick();
    push(32'h1111_2222);
    Reset = 1'b1;
    tick();
    chk("t5_pop_gated", 32'(popped), 32'd0);
    chk("t5_valid", 32'(bus.ResultValid), 32'd0);
    Reset = 1'b0;
    tick();
    chk("t5_hdr_pop", 32'(popped), 32'd1);
    chk("t5_drop", 32'(bus.DropCnt), 32'd1);

    // T6: DropCnt saturation, then packets still framed correctly.
    for (int i = 0; i < 300; i++) begin
      push(32'h0000_0000 + 32'(i));
      tick();
      if (i == 252) chk("t6_drop_fe", 32'(bus.DropCnt), 32'hFE);
    end
    chk("t6_drop_ff", 32'(bus.DropCnt), 32'hFF);
    push(32'hA5A5_0002); push(32'd10); push(32'd20); push(32'd30);
    exp_q.push_back({1'b0, 16'd2, 32'd30});
    take_result("t6_pkt");

    // MAGIC-looking payload word is plain payload.
    push(32'hA5A5_0001); push(32'hA5A5_0001); push(32'hA5A5_0001);
    exp_q.push_back({1'b0, 16'd1, 32'hA5A5_0001});
    take_result("magic_pay");

    // Maximum length packet: 64 words 1..64, sum 2080.
    push(32'hA5A5_0040);
    s = 32'd0;
    for (int i = 1; i <= 64; i++) begin
      push(32'(i));
      s = s + 32'(i);
      tick();
    end
    push(s);
    exp_q.push_back({1'b0, 16'd64, 32'd2080});
    take_result("max_len");
    chk("final_drop", 32'(bus.DropCnt), 32'hFF);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
